// File: rtl/multiplicador_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer:
// adder Control codes and the sequencer state encoding.
package multiplicador_pkg;

    // Control codes understood by the external ANCHO-bit adder
    localparam logic [3:0] CTRL_SUMA   = 4'b1000;
    localparam logic [3:0] CTRL_LIMPIA = 4'b0010;
    localparam logic [3:0] CTRL_NOP    = 4'b0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } estado_t;

    // True while a multiplication is in flight
    function automatic logic es_ocupado(input estado_t e);
        return (e == CLEAR) || (e == ADD) || (e == SHIFT);
    endfunction

endpackage

// File: rtl/control_multiplicador_registro_producto.sv
// Combined {carry, acc, mr} register of the shift-and-add multiplier.
// The FSM selects one action per cycle: load the multiplier operand,
// load the adder result into {carry, acc}, or shift the whole chain right.
module registro_producto #(
    parameter int ANCHO = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cargar,
    input  logic [ANCHO-1:0]   i_mr,
    input  logic               i_sumar,
    input  logic [ANCHO-1:0]   i_suma,
    input  logic               i_cout,
    input  logic               i_desplazar,
    output logic [ANCHO-1:0]   o_acc,
    output logic               o_mr_lsb,
    output logic [2*ANCHO-1:0] o_prod_sig
);

    logic [ANCHO-1:0] r_acc;
    logic [ANCHO-1:0] r_mr;
    logic             r_carry;

    logic [ANCHO-1:0] w_acc_sig;
    logic [ANCHO-1:0] w_mr_sig;

    // Value of {acc, mr} after one right shift with the carry entering at the top
    assign w_acc_sig  = {r_carry, r_acc[ANCHO-1:1]};
    assign w_mr_sig   = {r_acc[0], r_mr[ANCHO-1:1]};
    assign o_prod_sig = {w_acc_sig, w_mr_sig};
    assign o_acc      = r_acc;
    assign o_mr_lsb   = r_mr[0];

    // Register update: operand load, partial-sum capture or shift (mutually exclusive)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mr    <= '0;
            r_carry <= 1'b0;
        end else if (i_cargar) begin
            r_mr    <= i_mr;
        end else if (i_sumar) begin
            r_acc   <= i_suma;
            r_carry <= i_cout;
        end else if (i_desplazar) begin
            r_acc   <= w_acc_sig;
            r_mr    <= w_mr_sig;
            r_carry <= 1'b0;
        end
    end

endmodule

// File: rtl/control_multiplicador.sv
// Sequencer for an unsigned shift-and-add multiplier built around an
// external ANCHO-bit adder. Captures operands on start, walks ANCHO
// ADD/SHIFT iterations and publishes a 2*ANCHO-bit product with a
// one-cycle done pulse.
module control_multiplicador
    import multiplicador_pkg::*;
#(
    parameter int ANCHO = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ANCHO-1:0]   multiplicando,
    input  logic [ANCHO-1:0]   multiplicador,
    output logic               busy,
    output logic               done,
    output logic [2*ANCHO-1:0] producto,
    output logic [ANCHO-1:0]   sum_a,
    output logic [ANCHO-1:0]   sum_b,
    output logic               sum_cin,
    output logic [3:0]         sum_control,
    input  logic [ANCHO-1:0]   sum_res,
    input  logic               sum_cout
);

    localparam int CNT_W = $clog2(ANCHO + 1);

    estado_t            r_estado;
    estado_t            w_estado_sig;
    logic [ANCHO-1:0]   r_md;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*ANCHO-1:0] r_producto;

    logic               w_aceptar;
    logic               w_sumar;
    logic               w_desplazar;
    logic               w_ultima;
    logic [3:0]         w_control;
    logic [ANCHO-1:0]   w_acc;
    logic               w_mr_lsb;
    logic [2*ANCHO-1:0] w_prod_sig;

    registro_producto #(
        .ANCHO (ANCHO)
    ) u_registro (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cargar    (w_aceptar),
        .i_mr        (multiplicador),
        .i_sumar     (w_sumar),
        .i_suma      (sum_res),
        .i_cout      (sum_cout),
        .i_desplazar (w_desplazar),
        .o_acc       (w_acc),
        .o_mr_lsb    (w_mr_lsb),
        .o_prod_sig  (w_prod_sig)
    );

    assign w_ultima = (r_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state, adder Control code and datapath strobes
    always_comb begin
        w_estado_sig = r_estado;
        w_control    = CTRL_NOP;
        w_aceptar    = 1'b0;
        w_sumar      = 1'b0;
        w_desplazar  = 1'b0;
        case (r_estado)
            IDLE: begin
                if (start) begin
                    w_aceptar    = 1'b1;
                    w_estado_sig = CLEAR;
                end
            end
            CLEAR: begin
                // The adder returns zero on this code, which zeroes {carry, acc}
                w_control    = CTRL_LIMPIA;
                w_sumar      = 1'b1;
                w_estado_sig = ADD;
            end
            ADD: begin
                // On NOP the adder output is stale, so it is only captured on a real add
                if (w_mr_lsb) begin
                    w_control = CTRL_SUMA;
                    w_sumar   = 1'b1;
                end
                w_estado_sig = SHIFT;
            end
            SHIFT: begin
                w_desplazar  = 1'b1;
                w_estado_sig = w_ultima ? DONE : ADD;
            end
            DONE: begin
                if (start) begin
                    w_aceptar    = 1'b1;
                    w_estado_sig = CLEAR;
                end else begin
                    w_estado_sig = IDLE;
                end
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    // Multiplicand capture, iteration counter and product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md       <= '0;
            r_cnt      <= '0;
            r_producto <= '0;
        end else begin
            if (w_aceptar) begin
                r_md  <= multiplicando;
                r_cnt <= CNT_W'(ANCHO);
            end
            if (w_desplazar) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_ultima) begin
                    r_producto <= w_prod_sig;
                end
            end
        end
    end

    assign busy        = es_ocupado(r_estado);
    assign done        = (r_estado == DONE);
    assign producto    = r_producto;
    assign sum_a       = w_acc;
    assign sum_b       = r_md;
    assign sum_cin     = 1'b0;
    assign sum_control = w_control;

endmodule

// File: tb/tb_control_multiplicador.sv
// Scoreboard bench for control_multiplicador with a behavioural adder.
module tb_control_multiplicador;

    localparam int ANCHO = 8;
    localparam int LAT   = 17;  // accept edge to the edge that enters DONE

    typedef struct {
        logic [2*ANCHO-1:0] prod;
        int                 ciclo;
    } esperado_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [ANCHO-1:0]   multiplicando;
    logic [ANCHO-1:0]   multiplicador;
    logic               busy;
    logic               done;
    logic [2*ANCHO-1:0] producto;
    logic [ANCHO-1:0]   sum_a;
    logic [ANCHO-1:0]   sum_b;
    logic               sum_cin;
    logic [3:0]         sum_control;
    logic [ANCHO-1:0]   sum_res;
    logic               sum_cout;

    esperado_t cola[$];
    int        ciclo = 0;
    int        errores = 0;
    int        total = 0;
    logic      vio_suma;
    logic      vio_acc;
    logic      vio_carry;
    logic      ctrl_ilegal = 1'b0;

    control_multiplicador #(
        .ANCHO (ANCHO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .busy          (busy),
        .done          (done),
        .producto      (producto),
        .sum_a         (sum_a),
        .sum_b         (sum_b),
        .sum_cin       (sum_cin),
        .sum_control   (sum_control),
        .sum_res       (sum_res),
        .sum_cout      (sum_cout)
    );

    always #5 clk = ~clk;

    // Adder: add on 1000, zero on 0010, garbage otherwise (the sequencer must ignore it)
    always_comb begin
        sum_res  = 8'hA5;
        sum_cout = 1'b1;
        case (sum_control)
            4'b1000: {sum_cout, sum_res} = (ANCHO+1)'(sum_a) + (ANCHO+1)'(sum_b) + (ANCHO+1)'(sum_cin);
            4'b0010: begin
                sum_res  = '0;
                sum_cout = 1'b0;
            end
            default: begin
                sum_res  = 8'hA5;
                sum_cout = 1'b1;
            end
        endcase
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: obtenido=%0h esperado=%0h (ciclo %0d)", tag, obs, esp, ciclo);
        end
    endtask

    // One cycle: wait for the falling edge, observe, and retire completed results
    task automatic avanzar();
        esperado_t e;
        @(negedge clk);
        ciclo++;
        if (sum_control != 4'b0000 && sum_control != 4'b0010 && sum_control != 4'b1000)
            ctrl_ilegal = 1'b1;
        if (sum_control == 4'b1000) vio_suma = 1'b1;
        if (sum_a != '0) vio_acc = 1'b1;
        if (dut.u_registro.r_carry) vio_carry = 1'b1;
        if (done) begin
            if (cola.size() == 0) begin
                comprobar("done_espurio", 32'(done), 32'd0);
            end else begin
                e = cola.pop_front();
                comprobar("producto", 32'(producto), 32'(e.prod));
                comprobar("latencia", ciclo, e.ciclo);
            end
        end
    endtask

    // Request a product; must be called right after a falling edge with the DUT able to accept
    task automatic lanzar(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
        esperado_t e;
        start         = 1'b1;
        multiplicando = a;
        multiplicador = b;
        e.prod        = (2*ANCHO)'(a) * (2*ANCHO)'(b);
        e.ciclo       = ciclo + 1 + LAT;
        cola.push_back(e);
        avanzar();
        start         = 1'b0;
        multiplicando = ANCHO'($urandom);
        multiplicador = ANCHO'($urandom);
    endtask

    task automatic esperar_vacio();
        for (int i = 0; i < 60 && cola.size() != 0; i++) avanzar();
        if (cola.size() != 0) begin
            comprobar("timeout", cola.size(), 0);
            cola.delete();
        end
        avanzar();
        avanzar();
    endtask

    task automatic comprobar_reset();
        comprobar("rst_busy", 32'(busy), 0);
        comprobar("rst_done", 32'(done), 0);
        comprobar("rst_control", 32'(sum_control), 0);
        comprobar("rst_sum_a", 32'(sum_a), 0);
        comprobar("rst_sum_b", 32'(sum_b), 0);
        comprobar("rst_cin", 32'(sum_cin), 0);
        comprobar("rst_producto", 32'(producto), 0);
        comprobar("rst_estado", 32'(dut.r_estado), 0);
    endtask

    initial begin
        int e0;
        rst_n         = 1'b0;
        start         = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        vio_suma      = 1'b0;
        vio_acc       = 1'b0;
        vio_carry     = 1'b0;
        #1;
        comprobar_reset();
        avanzar();
        avanzar();
        rst_n = 1'b1;
        avanzar();

        // Basic 13*11 with busy profile
        lanzar(8'd13, 8'd11);
        comprobar("busy_c1", 32'(busy), 1);
        for (int k = 2; k <= 17; k++) begin
            avanzar();
            comprobar("busy_ciclo", 32'(busy), 1);
        end
        avanzar();
        comprobar("busy_done", 32'(busy), 0);
        comprobar("done_ciclo18", 32'(done), 1);
        esperar_vacio();
        comprobar("producto_mantiene", 32'(producto), 32'h008F);

        // Carry path
        vio_carry = 1'b0;
        lanzar(8'd255, 8'd255);
        esperar_vacio();
        comprobar("carry_visto", 32'(vio_carry), 1);

        // 0*200: adds happen but the accumulator stays zero
        lanzar(8'd0, 8'd200);
        vio_suma = 1'b0;
        vio_acc  = 1'b0;
        esperar_vacio();
        comprobar("cero_suma_hay", 32'(vio_suma), 1);
        comprobar("cero_acc_quieto", 32'(vio_acc), 0);

        // 200*0: the adder is never asked to add
        lanzar(8'd200, 8'd0);
        vio_suma = 1'b0;
        esperar_vacio();
        comprobar("sin_suma", 32'(vio_suma), 0);

        // Start while busy is dropped
        lanzar(8'd7, 8'd9);
        repeat (3) avanzar();
        start         = 1'b1;
        multiplicando = 8'd100;
        multiplicador = 8'd100;
        repeat (2) avanzar();
        start = 1'b0;
        esperar_vacio();
        repeat (22) avanzar();

        // Back-to-back with start held high
        e0 = ciclo + 1;
        cola.push_back('{prod: 16'd42,  ciclo: e0 + LAT});
        cola.push_back('{prod: 16'd144, ciclo: e0 + LAT + 1 + LAT});
        start         = 1'b1;
        multiplicando = 8'd6;
        multiplicador = 8'd7;
        avanzar();
        repeat (4) avanzar();
        multiplicando = 8'd12;
        multiplicador = 8'd12;
        for (int i = 0; i < 40 && ciclo < e0 + LAT; i++) avanzar();
        avanzar();
        start = 1'b0;
        comprobar("b2b_sin_idle", 32'(busy), 1);
        esperar_vacio();

        // Asynchronous reset at random points of an operation
        for (int r = 0; r < 3; r++) begin
            lanzar(ANCHO'($urandom), ANCHO'($urandom));
            repeat ($urandom_range(1, 15)) avanzar();
            #2;
            rst_n = 1'b0;
            #1;
            comprobar_reset();
            cola.delete();
            avanzar();
            avanzar();
            rst_n = 1'b1;
            avanzar();
            lanzar(8'd3, 8'd5);
            esperar_vacio();
        end

        // Random products
        for (int i = 0; i < 6; i++) begin
            lanzar(ANCHO'($urandom), ANCHO'($urandom));
            esperar_vacio();
        end

        comprobar("control_legal", 32'(ctrl_ilegal), 0);
        $display("Result: errors=%0d of %0d checks", errores, total);
        $finish;
    end

endmodule
